// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 16-bit 5-stage core.
// Drives IF/ID, ID/EX and EX/MEM enables and flushes, and keeps saturating performance counters.
module hazard_ctrl #(
    parameter int BR_PENALTY = 1,
    parameter int R0_ZERO    = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [2:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwr,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t     state_r;
    state_t     next_state;
    logic [2:0] fl_cnt;
    logic [2:0] next_fl;
    logic       stall_inc;
    logic       flush_inc;
    logic       load_use;
    logic       mem_stall;
    logic       rd_is_zero;

    assign rd_is_zero = (R0_ZERO != 0) && (ex_rd == 3'd0);
    assign load_use   = id_valid && ex_memread && ex_regwr && !rd_is_zero &&
                        ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign mem_stall  = mem_req && !mem_ready;
    assign state      = state_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= RUN;
            fl_cnt    <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_r <= next_state;
            fl_cnt  <= next_fl;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Outputs act in the same cycle as the inputs that cause them; reset forces every enable low.
    always_comb begin
        next_state = state_r;
        next_fl    = fl_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        case (state_r)
            RUN: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    stall_inc  = 1'b1;
                    next_state = MEMWAIT;
                end else if (ex_br_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    if (BR_PENALTY > 1) begin
                        next_state = FLUSH;
                        next_fl    = 3'(BR_PENALTY - 1);
                    end
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end
            end

            FLUSH: begin
                // A memory wait takes over and the remaining wrong-path flush cycles are dropped.
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    stall_inc  = 1'b1;
                    next_state = MEMWAIT;
                    next_fl    = 3'd0;
                end else begin
                    ifid_flush = 1'b1;
                    if (fl_cnt <= 3'd1) begin
                        next_state = RUN;
                        next_fl    = 3'd0;
                    end else begin
                        next_fl = fl_cnt - 3'd1;
                    end
                end
            end

            MEMWAIT: begin
                // Branches and load-use seen here are replayed by the frozen EX instruction after release.
                if (mem_ready) begin
                    next_state = RUN;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    pipe_hold  = 1'b1;
                    stall_inc  = 1'b1;
                end
            end

            default: begin
                next_state = RUN;
                next_fl    = 3'd0;
            end
        endcase

        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            pipe_hold  = 1'b0;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for single-cycle hazards plus hand sequences
// for branch penalty, memory wait, priority, reset and counter saturation.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       id_valid;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       uses_rs2;
        logic [2:0] rd;
        logic       memread;
        logic       regwr;
        logic       br;
        logic       mem_req;
        logic       mem_ready;
    } in_t;

    typedef struct packed {
        in_t         stim;
        logic [4:0]  exp_ctrl;
        logic [15:0] exp_stall;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        id_valid, id_uses_rs2, ex_memread, ex_regwr, ex_br_taken, mem_req, mem_ready;
    logic [2:0]  id_rs1, id_rs2, ex_rd;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_write7, ifid_write7, ifid_flush7, idex_flush7, pipe_hold7;
    logic [1:0]  state7;
    logic [2:0]  stall_cnt7, flush_cnt7;

    logic [4:0]  ctrl, ctrl7;
    int          passed = 0;
    int          total  = 0;
    vec_t        vecs[11];
    in_t         idle, lu;

    assign ctrl  = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold};
    assign ctrl7 = {pc_write7, ifid_write7, ifid_flush7, idex_flush7, pipe_hold7};

    hazard_ctrl #(.BR_PENALTY(3), .R0_ZERO(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwr(ex_regwr),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_hold(pipe_hold), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Long-penalty instance with narrow counters, used for reset-mid-flush and saturation.
    hazard_ctrl #(.BR_PENALTY(7), .R0_ZERO(1), .CNT_W(3)) dut7 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwr(ex_regwr),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write7), .ifid_write(ifid_write7), .ifid_flush(ifid_flush7),
        .idex_flush(idex_flush7), .pipe_hold(pipe_hold7), .state(state7),
        .stall_cnt(stall_cnt7), .flush_cnt(flush_cnt7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mkin(logic v, logic [2:0] r1, logic [2:0] r2, logic u2, logic [2:0] rd,
                                 logic mr, logic rw, logic br, logic mq, logic my);
        in_t t;
        t.id_valid = v;  t.rs1 = r1;     t.rs2 = r2;   t.uses_rs2 = u2; t.rd = rd;
        t.memread  = mr; t.regwr = rw;   t.br = br;    t.mem_req = mq;  t.mem_ready = my;
        return t;
    endfunction

    task automatic applyStimulus(input in_t t);
        id_valid    = t.id_valid;
        id_rs1      = t.rs1;
        id_rs2      = t.rs2;
        id_uses_rs2 = t.uses_rs2;
        ex_rd       = t.rd;
        ex_memread  = t.memread;
        ex_regwr    = t.regwr;
        ex_br_taken = t.br;
        mem_req     = t.mem_req;
        mem_ready   = t.mem_ready;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        applyStimulus(idle);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu   = mkin(1, 3'd3, 3'd0, 0, 3'd3, 1, 1, 0, 0, 0);

        vecs[0]  = '{idle,                                   5'b11000, 16'd0};
        vecs[1]  = '{lu,                                     5'b00010, 16'd1};
        vecs[2]  = '{idle,                                   5'b11000, 16'd1};
        vecs[3]  = '{mkin(1, 3'd5, 3'd2, 0, 3'd2, 1, 1, 0, 0, 0), 5'b11000, 16'd1};
        vecs[4]  = '{mkin(1, 3'd5, 3'd2, 1, 3'd2, 1, 1, 0, 0, 0), 5'b00010, 16'd2};
        vecs[5]  = '{mkin(1, 3'd0, 3'd1, 0, 3'd0, 1, 1, 0, 0, 0), 5'b11000, 16'd2};
        vecs[6]  = '{mkin(1, 3'd4, 3'd1, 0, 3'd4, 0, 1, 0, 0, 0), 5'b11000, 16'd2};
        vecs[7]  = '{mkin(1, 3'd4, 3'd1, 0, 3'd4, 1, 0, 0, 0, 0), 5'b11000, 16'd2};
        vecs[8]  = '{mkin(0, 3'd4, 3'd1, 0, 3'd4, 1, 1, 0, 0, 0), 5'b11000, 16'd2};
        vecs[9]  = '{mkin(0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 1, 1), 5'b11000, 16'd2};
        vecs[10] = '{mkin(1, 3'd6, 3'd0, 0, 3'd6, 1, 1, 0, 1, 1), 5'b00010, 16'd3};

        reset = 1'b1;
        applyStimulus(idle);
        #2;
        checkOutput("reset_ctrl", 32'(ctrl), 32'b00000);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_stall", 32'(stall_cnt), 32'd0);
        checkOutput("reset_flush", 32'(flush_cnt), 32'd0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].stim);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
            tick();
            checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'd0);
            checkOutput($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
        end

        // Branch with penalty 3; load-use presented during FLUSH must be ignored.
        doReset();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        checkOutput("br_c0_ctrl", 32'(ctrl), 32'b11110);
        tick();
        applyStimulus(lu);
        @(negedge clk);
        checkOutput("br_c1_state", 32'(state), 32'd1);
        checkOutput("br_c1_ctrl", 32'(ctrl), 32'b11100);
        tick();
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("br_c2_state", 32'(state), 32'd1);
        checkOutput("br_c2_ctrl", 32'(ctrl), 32'b11100);
        tick();
        @(negedge clk);
        checkOutput("br_c3_state", 32'(state), 32'd0);
        checkOutput("br_c3_ctrl", 32'(ctrl), 32'b11000);
        checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Four not-ready cycles followed by the release cycle.
        doReset();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        checkOutput("mw_c0_ctrl", 32'(ctrl), 32'b00001);
        checkOutput("mw_c0_state", 32'(state), 32'd0);
        for (int c = 1; c < 4; c++) begin
            tick();
            @(negedge clk);
            checkOutput($sformatf("mw_c%0d_state", c), 32'(state), 32'd2);
            checkOutput($sformatf("mw_c%0d_ctrl", c), 32'(ctrl), 32'b00001);
        end
        tick();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        @(negedge clk);
        checkOutput("mw_rel_ctrl", 32'(ctrl), 32'b11000);
        tick();
        applyStimulus(idle);
        checkOutput("mw_end_state", 32'(state), 32'd0);
        checkOutput("mw_stall_cnt", 32'(stall_cnt), 32'd4);

        // Branch beats load-use; then memory wait beats branch and the branch replays afterwards.
        doReset();
        applyStimulus(mkin(1, 3'd3, 3'd0, 0, 3'd3, 1, 1, 1, 0, 0));
        @(negedge clk);
        checkOutput("sim_br_lu_ctrl", 32'(ctrl), 32'b11110);
        tick();
        checkOutput("sim_br_lu_stall", 32'(stall_cnt), 32'd0);
        checkOutput("sim_br_lu_flush", 32'(flush_cnt), 32'd1);
        applyStimulus(idle);
        tick();
        tick();
        checkOutput("sim_back_run", 32'(state), 32'd0);
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        @(negedge clk);
        checkOutput("sim_mw_br_ctrl0", 32'(ctrl), 32'b00001);
        tick();
        @(negedge clk);
        checkOutput("sim_mw_br_state", 32'(state), 32'd2);
        checkOutput("sim_mw_br_ctrl1", 32'(ctrl), 32'b00001);
        tick();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        @(negedge clk);
        checkOutput("sim_rel_ctrl", 32'(ctrl), 32'b11000);
        tick();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        checkOutput("sim_replay_ctrl", 32'(ctrl), 32'b11110);
        tick();
        applyStimulus(idle);
        checkOutput("sim_replay_state", 32'(state), 32'd1);
        checkOutput("sim_flush_cnt", 32'(flush_cnt), 32'd2);
        checkOutput("sim_stall_cnt", 32'(stall_cnt), 32'd2);

        // Memory wait during FLUSH abandons the remaining flush cycles.
        doReset();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tick();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        checkOutput("abn_ctrl", 32'(ctrl), 32'b00001);
        tick();
        checkOutput("abn_state_mw", 32'(state), 32'd2);
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tick();
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("abn_state_run", 32'(state), 32'd0);
        checkOutput("abn_no_flush", 32'(ctrl), 32'b11000);

        // Reset asserted mid-FLUSH on the penalty-7 instance.
        doReset();
        applyStimulus(mkin(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        @(negedge clk);
        checkOutput("rst7_br_ctrl", 32'(ctrl7), 32'b11110);
        tick();
        applyStimulus(idle);
        tick();
        checkOutput("rst7_in_flush", 32'(state7), 32'd1);
        checkOutput("rst7_flush_pre", 32'(flush_cnt7), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst7_state", 32'(state7), 32'd0);
        checkOutput("rst7_ctrl", 32'(ctrl7), 32'b00000);
        checkOutput("rst7_flush_cnt", 32'(flush_cnt7), 32'd0);
        tick();
        checkOutput("rst7_hold_ctrl", 32'(ctrl7), 32'b00000);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst7_rel_ctrl", 32'(ctrl7), 32'b11000);
        checkOutput("rst7_rel_state", 32'(state7), 32'd0);

        // Nine load-use stalls saturate the 3-bit counter at 7.
        doReset();
        applyStimulus(lu);
        for (int k = 0; k < 9; k++) tick();
        applyStimulus(idle);
        checkOutput("sat_stall7", 32'(stall_cnt7), 32'd7);
        checkOutput("sat_stall16", 32'(stall_cnt), 32'd9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 16-bit 5-stage core.
- Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and flush inputs; the ID/EX bubble is injected through its flush input.
- Resolves load-use hazards, taken-branch flushes (branch resolved in EX) and data-memory wait states.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- BR_PENALTY, 1, total cycles IF/ID is flushed after a taken branch (1..7).
- R0_ZERO, 1, when 1 a destination of r0 never causes a load-use hazard.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  3  ID source register 1.
- id_rs2  input  3  ID source register 2.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  3  EX destination register (ID/EX ins_wr output).
- ex_memread  input  1  EX instruction is a load.
- ex_regwr  input  1  EX instruction writes the register file.
- ex_br_taken  input  1  EX branch resolved taken this cycle.
- mem_req  input  1  MEM stage is accessing data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  IF/ID clears to NOP on the next edge.
- idex_flush  output  1  ID/EX loads a bubble (all controls 0) on the next edge.
- pipe_hold  output  1  freeze ID/EX and EX/MEM (memory wait).
- state  output  2  FSM state: 0 RUN, 1 FLUSH, 2 MEMWAIT.
- stall_cnt  output  CNT_W  load-use plus memory-wait stall cycles.
- flush_cnt  output  CNT_W  taken branches flushed.

Behaviour:
- FSM states: RUN, FLUSH, MEMWAIT. A down-counter fl_cnt (3 bits) is used in FLUSH.
- Control outputs are combinational from state and current inputs, with the same-cycle effect.
- While reset is high: state=RUN, fl_cnt=0, counters=0, pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, pipe_hold=0.
- Default (no event): pc_write=1, ifid_write=1, all flushes and pipe_hold=0.
- load_use = id_valid & ex_memread & ex_regwr & !(R0_ZERO & ex_rd==0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
- RUN priority, highest first:
  - mem_req & !mem_ready: pc_write=0, ifid_write=0, pipe_hold=1. Next state MEMWAIT. stall_cnt++.
  - ex_br_taken: ifid_flush=1, idex_flush=1, PC writes the target. flush_cnt++. If BR_PENALTY>1, next state FLUSH with fl_cnt=BR_PENALTY-1; otherwise stay in RUN.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle. stall_cnt++. Stay in RUN. The next cycle re-evaluates; the load is then in MEM, so no repeat.
- MEMWAIT:
  - Outputs: pc_write=0, ifid_write=0, pipe_hold=1. stall_cnt++ each cycle.
  - Exit to RUN in the cycle mem_ready=1; that cycle already uses RUN default outputs with pipe_hold=0.
  - ex_br_taken and load_use are ignored while in MEMWAIT. The frozen EX instruction presents them again in RUN.
- FLUSH:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0. fl_cnt decrements; go to RUN when fl_cnt==1.
  - A new mem_req & !mem_ready in FLUSH goes to MEMWAIT and abandons the remaining flush cycles.
  - load_use is ignored in FLUSH, since the ID instruction is being discarded.
- A taken branch and a load-use in the same RUN cycle: the branch wins and only flush_cnt increments.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-MEMWAIT or mid-FLUSH returns to RUN immediately (asynchronous); counters clear.
- Unused state encoding 3 returns to RUN on the next edge with default outputs.

Test Plan:
- Load-use on rs1: ex_memread=1, ex_regwr=1, ex_rd=3, id_rs1=3, id_valid=1 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle, stall_cnt=1; next cycle outputs return to default.
- rs2 masking and r0 rule: ex_rd=2, id_rs2=2, id_uses_rs2=0 -> no stall. Then ex_rd=0=id_rs1 with R0_ZERO=1 -> no stall, stall_cnt=0.
- Branch penalty: BR_PENALTY=3, ex_br_taken pulse -> cycle 0: ifid_flush=1, idex_flush=1; cycles 1-2: ifid_flush=1, state=FLUSH; cycle 3: RUN; flush_cnt=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles then 1 -> pipe_hold=1 and pc_write=0 for 4 cycles, state=MEMWAIT, stall_cnt=4; the release cycle has pipe_hold=0.
- Simultaneous events: ex_br_taken=1 with load_use=1 -> flush only, stall_cnt unchanged. Then mem wait together with ex_br_taken -> MEMWAIT first, branch flush in the cycle after mem_ready.
- Reset mid-FLUSH (BR_PENALTY=7, reset at cycle 2) -> state=RUN, counters=0, all enables 0 while reset is high, defaults after release.
